// File: rtl/sram_mem_controller.sv
// Memory-stage controller for a 16-bit asynchronous SRAM. Each 32-bit access
// runs as two halfword phases, and ready stays low until the access finishes.
module sram_mem_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn,
  input  logic               rdEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam logic [3:0] LAST_COUNT = 4'(WAIT_CYCLES - 1);

  state_t             state;
  logic [3:0]         counter;
  logic               isWrite;
  logic [15:0]        wdHigh;
  logic [SRAM_AW-1:0] baseAddr;
  logic [SRAM_AW-1:0] baseNext;
  logic               request;

  assign request = wrEn | rdEn;

  // Halfword index of the word, bit0 cleared so base+1 never carries.
  always_comb begin
    baseNext = SRAM_AW'((address - 32'(BASE_ADDR)) >> 1) & ~SRAM_AW'(1);
  end

  always_comb begin
    ready = ((state == IDLE) && !request) || (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= '0;
      isWrite   <= 1'b0;
      wdHigh    <= '0;
      baseAddr  <= '0;
      readData  <= '0;
      sramAddr  <= '0;
      sramDqOut <= '0;
      sramDqOe  <= 1'b0;
      sramWeN   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          sramDqOe <= 1'b0;
          sramWeN  <= 1'b1;
          if (request) begin
            isWrite  <= wrEn;
            wdHigh   <= writeData[31:16];
            baseAddr <= baseNext;
            counter  <= '0;
            sramAddr <= baseNext;
            state    <= LOW;
            if (wrEn) begin
              sramDqOut <= writeData[15:0];
              sramDqOe  <= 1'b1;
              sramWeN   <= 1'b0;
            end
          end
        end

        LOW: begin
          if (counter == LAST_COUNT) begin
            counter  <= '0;
            state    <= HIGH;
            sramAddr <= baseAddr | SRAM_AW'(1);
            if (isWrite) begin
              sramDqOut <= wdHigh;
            end else begin
              readData[15:0] <= sramDqIn;
            end
          end else begin
            counter <= counter + 4'd1;
          end
        end

        HIGH: begin
          if (counter == LAST_COUNT) begin
            counter  <= '0;
            state    <= DONE;
            sramDqOe <= 1'b0;
            sramWeN  <= 1'b1;
            if (!isWrite) begin
              readData[31:16] <= sramDqIn;
            end
          end else begin
            counter <= counter + 4'd1;
          end
        end

        DONE: begin
          counter <= '0;
          state   <= IDLE;
        end

        default: begin
          counter <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// Bench for sram_mem_controller: directed and random word accesses against a
// halfword SRAM model, checked per cycle against a word-level reference.
module tb_sram_mem_controller;

  localparam int W  = 3;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          wrEn, rdEn;
  logic [31:0]   address, writeData;
  logic [31:0]   readData;
  logic          ready;
  logic [AW-1:0] sramAddr;
  logic [15:0]   sramDqOut;
  logic [15:0]   sramDqIn;
  logic          sramDqOe;
  logic          sramWeN;

  int total = 0;
  int bad   = 0;

  // SRAM contents: written halfwords, otherwise a fixed address-derived pattern
  logic [15:0] sramMem [int unsigned];
  // Reference: whole words keyed by their low halfword address
  logic [31:0] refMem [int unsigned];
  logic [31:0] prevRead;

  sram_mem_controller #(
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(W),
    .SRAM_AW    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wrEn     (wrEn),
    .rdEn     (rdEn),
    .address  (address),
    .writeData(writeData),
    .readData (readData),
    .ready    (ready),
    .sramAddr (sramAddr),
    .sramDqOut(sramDqOut),
    .sramDqIn (sramDqIn),
    .sramDqOe (sramDqOe),
    .sramWeN  (sramWeN)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int unsigned a);
    logic [31:0] t;
    t = a;
    return t[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] sramRead(input int unsigned a);
    if (sramMem.exists(a)) return sramMem[a];
    return pat(a);
  endfunction

  always @(posedge clk) begin
    if (!sramWeN) sramMem[int'(sramAddr)] = sramDqOut;
  end

  always @(negedge clk or sramAddr) begin
    sramDqIn = sramRead(int'(sramAddr));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access starting in an IDLE cycle (entered at posedge+1); returns at
  // posedge+1 of the IDLE cycle following DONE with requests dropped.
  task automatic doAccess(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data);
    logic        isWr;
    logic [31:0] lo;
    logic [31:0] expWord;
    logic [15:0] dq;
    logic [31:0] ph;
    isWr = wr;
    lo = (((addr - 32'd1024) >> 2) * 32'd2) % 32'h40000;
    expWord = refMem.exists(lo) ? refMem[lo] : {pat(lo + 1), pat(lo)};
    wrEn = wr; rdEn = rd; address = addr; writeData = data;
    for (int k = 0; k <= 2 * W + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("ready_c0", 32'(ready), 32'd0);
      end else if (k <= 2 * W) begin
        ph = (k <= W) ? lo : lo + 1;
        dq = (k <= W) ? data[15:0] : data[31:16];
        chk("ready_busy", 32'(ready), 32'd0);
        chk("sramAddr", 32'(sramAddr), ph);
        chk("weN", 32'(sramWeN), isWr ? 32'd0 : 32'd1);
        chk("oe", 32'(sramDqOe), isWr ? 32'd1 : 32'd0);
        if (isWr) chk("dqOut", 32'(sramDqOut), 32'(dq));
      end else begin
        chk("ready_done", 32'(ready), 32'd1);
        chk("weN_done", 32'(sramWeN), 32'd1);
        chk("oe_done", 32'(sramDqOe), 32'd0);
        chk("readData_done", readData, isWr ? prevRead : expWord);
      end
      @(posedge clk); #1;
    end
    if (isWr) refMem[lo] = data;
    else prevRead = expWord;
    wrEn = 1'b0; rdEn = 1'b0;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);
    chk("idle_weN", 32'(sramWeN), 32'd1);
    chk("idle_readData", readData, prevRead);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        op;
    rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = '0; writeData = '0;
    prevRead = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_weN", 32'(sramWeN), 32'd1);
    chk("rst_oe", 32'(sramDqOe), 32'd0);
    chk("rst_readData", readData, 32'd0);
    @(posedge clk); #1;
    idleCycle();

    doAccess(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
    idleCycle();
    doAccess(1'b0, 1'b1, 32'd1032, 32'h0);
    chk("readback", prevRead, 32'hDEADBEEF);
    idleCycle();
    idleCycle();
    doAccess(1'b1, 1'b1, 32'd1024, 32'h12345678);
    idleCycle();
    doAccess(1'b0, 1'b1, 32'd1028, 32'h0);
    doAccess(1'b0, 1'b1, 32'd1032, 32'h0);
    idleCycle();
    doAccess(1'b1, 1'b0, 32'h0000_0000, 32'hCAFE0001);
    doAccess(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hCAFE0002);
    doAccess(1'b0, 1'b1, 32'h0000_0000, 32'h0);
    doAccess(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    doAccess(1'b0, 1'b1, 32'd1024, 32'h0);
    idleCycle();

    for (int i = 0; i < 24; i++) begin
      a  = 32'd1024 + 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      d  = $urandom;
      op = 1'($urandom_range(0, 1));
      doAccess(op, ~op, a, d);
      if ($urandom_range(0, 1) == 1) idleCycle();
    end

    // reset in cycle 2 of a write
    wrEn = 1'b1; rdEn = 1'b0; address = 32'd2048; writeData = 32'h0BAD0BAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_weN_low", 32'(sramWeN), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_weN", 32'(sramWeN), 32'd1);
    chk("arst_oe", 32'(sramDqOe), 32'd0);
    chk("arst_readData", readData, 32'd0);
    chk("arst_busy_req", 32'(ready), 32'd0);
    wrEn = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    prevRead = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    idleCycle();
    doAccess(1'b0, 1'b1, 32'd1032, 32'h0);
    idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
